// File: rtl/median_pkg.sv
// Shared definitions for the median filter pixel-window interface.
package median_pkg;

  localparam int unsigned MEDIAN_PIX_W = 8;
  localparam int unsigned DEF_IMG_W    = 640;
  localparam int unsigned DEF_IMG_H    = 480;
  localparam int unsigned WIN_TAPS     = 9;

  // Index 0 is P1 (top-left), index 8 is P9 (bottom-right, newest pixel).
  typedef logic [WIN_TAPS-1:0][MEDIAN_PIX_W-1:0] window_t;

endpackage

// File: rtl/line_buffer.sv
// Fixed-length delay line: the output is the value written DEPTH enables earlier.
module line_buffer #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_ptr;

  // Read-before-write: the slot about to be overwritten holds the oldest sample.
  assign o_dout = r_mem[r_ptr];

  // Storage is deliberately not reset; the consumer never exposes stale entries.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[r_ptr] <= i_din;
    end
  end

  // Circular pointer advance on every enabled shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + AW'(1);
    end
  end

endmodule

// File: rtl/median_window_gen.sv
// Raster-stream to 3x3 window generator feeding median_filter.
module median_window_gen
  import median_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H,
  parameter int unsigned PIX_W = MEDIAN_PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             pix_sof,
  output logic             in_ready,
  output logic [PIX_W-1:0] P1,
  output logic [PIX_W-1:0] P2,
  output logic [PIX_W-1:0] P3,
  output logic [PIX_W-1:0] P4,
  output logic [PIX_W-1:0] P5,
  output logic [PIX_W-1:0] P6,
  output logic [PIX_W-1:0] P7,
  output logic [PIX_W-1:0] P8,
  output logic [PIX_W-1:0] P9,
  output logic             win_valid,
  output logic             win_eof,
  input  logic             out_ready
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [WIN_TAPS-1:0][PIX_W-1:0] r_win;
  logic          r_valid;
  logic          r_eof;

  logic          w_accept;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col_nxt;
  logic [RW-1:0] w_row_nxt;
  logic          w_qualify;
  logic          w_last;
  logic [PIX_W-1:0] w_lb0_out;
  logic [PIX_W-1:0] w_lb1_out;

  // Single-entry output stage: a new pixel may enter only if the window slot frees up.
  assign in_ready = !r_valid || out_ready;
  assign w_accept = pix_valid && in_ready;

  // sof relocates the current pixel to the frame origin.
  assign w_col     = pix_sof ? '0 : r_col;
  assign w_row     = pix_sof ? '0 : r_row;
  assign w_qualify = (w_row >= RW'(2)) && (w_col >= CW'(2));
  assign w_last    = (w_row == RW'(IMG_H - 1)) && (w_col == CW'(IMG_W - 1));

  // Next raster position after the accepted pixel.
  always_comb begin
    w_col_nxt = w_col + CW'(1);
    w_row_nxt = w_row;
    if (w_col == CW'(IMG_W - 1)) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == RW'(IMG_H - 1)) ? '0 : w_row + RW'(1);
    end
  end

  // LB0 delays by one line (row r-1), LB1 by two lines (row r-2).
  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb0 (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_accept),
    .i_din  (pix_in),
    .o_dout (w_lb0_out)
  );

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb1 (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_accept),
    .i_din  (w_lb0_out),
    .o_dout (w_lb1_out)
  );

  // Raster position counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  // Window shift and output handshake; non-qualifying accepts still shift the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win   <= '0;
      r_valid <= 1'b0;
      r_eof   <= 1'b0;
    end else if (w_accept) begin
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= w_lb1_out;
      r_win[3] <= r_win[4];
      r_win[4] <= r_win[5];
      r_win[5] <= w_lb0_out;
      r_win[6] <= r_win[7];
      r_win[7] <= r_win[8];
      r_win[8] <= pix_in;
      r_valid  <= w_qualify;
      r_eof    <= w_qualify && w_last;
    end else if (out_ready) begin
      r_valid <= 1'b0;
      r_eof   <= 1'b0;
    end
  end

  assign P1        = r_win[0];
  assign P2        = r_win[1];
  assign P3        = r_win[2];
  assign P4        = r_win[3];
  assign P5        = r_win[4];
  assign P6        = r_win[5];
  assign P7        = r_win[6];
  assign P8        = r_win[7];
  assign P9        = r_win[8];
  assign win_valid = r_valid;
  assign win_eof   = r_eof;

endmodule

// File: tb/tb_median_window_gen.sv
// Scoreboard bench for median_window_gen on a small 8x6 image.
module tb_median_window_gen;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       pix_sof;
  logic       in_ready;
  logic [7:0] P1, P2, P3, P4, P5, P6, P7, P8, P9;
  logic       win_valid;
  logic       win_eof;
  logic       out_ready;

  always #5 clk = ~clk;

  median_window_gen #(
    .IMG_W (W),
    .IMG_H (H),
    .PIX_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .in_ready  (in_ready),
    .P1        (P1),
    .P2        (P2),
    .P3        (P3),
    .P4        (P4),
    .P5        (P5),
    .P6        (P6),
    .P7        (P7),
    .P8        (P8),
    .P9        (P9),
    .win_valid (win_valid),
    .win_eof   (win_eof),
    .out_ready (out_ready)
  );

  typedef struct packed {
    logic [8:0][7:0] p;
    logic            eof;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   win_cnt = 0;
  int   eof_cnt = 0;

  // ---------------- reference model: image array indexed by (row, col) ----------------
  logic [7:0] img [H][W];
  int         mr = 0;
  int         mc = 0;
  logic       acc_n = 1'b0;
  logic       sof_n = 1'b0;
  logic [7:0] pix_n = '0;
  exp_t       e_new;

  always @(negedge clk) begin
    acc_n = pix_valid && in_ready;
    sof_n = pix_sof;
    pix_n = pix_in;
  end

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      mr = 0;
      mc = 0;
    end else if (acc_n) begin
      if (sof_n) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = pix_n;
      if (mr >= 2 && mc >= 2) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e_new.p[i*3+j] = img[mr-2+i][mc-2+j];
        e_new.eof = (mr == H - 1) && (mc == W - 1);
        q.push_back(e_new);
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [8:0][7:0] got;
  logic [8:0][7:0] prev_got = '0;
  logic            prev_eof = 1'b0;
  logic            hold_prev = 1'b0;
  exp_t            e_pop;

  always @(negedge clk) begin
    got = {P9, P8, P7, P6, P5, P4, P3, P2, P1};
    if (!rst) begin
      checks++;
      if (win_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL valid_latency: win_valid=%0b expected=%0b (pending=%0d) t=%0t",
                 win_valid, q.size() != 0, q.size(), $time);
      end
      checks++;
      if (in_ready !== (!win_valid || out_ready)) begin
        errors++;
        $display("FAIL in_ready: got=%0b expected=%0b t=%0t", in_ready,
                 !win_valid || out_ready, $time);
      end
      checks++;
      if (win_eof && !win_valid) begin
        errors++;
        $display("FAIL eof_without_valid: win_eof=1 win_valid=0 expected win_eof=0 t=%0t", $time);
      end
      if (hold_prev) begin
        checks++;
        if (!win_valid || got != prev_got || win_eof != prev_eof) begin
          errors++;
          $display("FAIL hold: got v=%0b w=%h e=%0b expected v=1 w=%h e=%0b t=%0t",
                   win_valid, got, win_eof, prev_got, prev_eof, $time);
        end
      end
      if (win_valid && out_ready && q.size() != 0) begin
        e_pop = q.pop_front();
        checks++;
        if (got != e_pop.p || win_eof != e_pop.eof) begin
          errors++;
          $display("FAIL window: got w=%h e=%0b expected w=%h e=%0b t=%0t",
                   got, win_eof, e_pop.p, e_pop.eof, $time);
        end
        win_cnt++;
        if (win_eof) eof_cnt++;
      end
      hold_prev = win_valid && !out_ready;
      prev_got  = got;
      prev_eof  = win_eof;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // ---------------- out_ready driver ----------------
  int   or_mode = 0;  // 0: always ready, 1: random, 2: forced low
  logic bp_arm = 1'b0;
  logic bp_hit = 1'b0;
  int   bp_cnt = 0;

  always @(posedge clk) begin
    #2;
    if (or_mode == 2) begin
      out_ready = 1'b0;
    end else if (bp_cnt > 0) begin
      out_ready = 1'b0;
      bp_cnt--;
    end else if (bp_arm && win_valid && P9 == 8'h34) begin
      bp_arm    = 1'b0;
      bp_hit    = 1'b1;
      bp_cnt    = 4;
      out_ready = 1'b0;
    end else if (or_mode == 1) begin
      out_ready = 1'($urandom_range(0, 1));
    end else begin
      out_ready = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_int(input string name, input int got_v, input int exp_v);
    checks++;
    if (got_v != exp_v) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", name, got_v, exp_v);
    end
  endtask

  // Leaves pix_valid high so consecutive calls form a continuous stream.
  task automatic send(input logic [7:0] v, input logic sof);
    int   n;
    logic ok;
    n = 0;
    pix_in    = v;
    pix_sof   = sof;
    pix_valid = 1'b1;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: pixel %h not accepted within 200 cycles, expected accept", v);
        break;
      end
    end
    pix_sof = 1'b0;
  endtask

  task automatic idle();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  // Sends pixels of the raster from (0,0) up to but excluding (stop_r, stop_c).
  task automatic send_pixels(input logic [7:0] x, input logic sof_first, input logic bubbles,
                             input int stop_r, input int stop_c);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) return;
        if (bubbles && $urandom_range(0, 1) == 1) begin
          pix_valid = 1'b0;
          @(posedge clk);
          #1;
        end
        send(8'((16 * r + c)) ^ x, sof_first && r == 0 && c == 0);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || win_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL drain: %0d windows still pending after 1000 cycles, expected 0", q.size());
    end
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clk);
    checks++;
    if (win_valid !== 1'b0 || win_eof !== 1'b0 || in_ready !== 1'b1 ||
        {P1, P2, P3, P4, P5, P6, P7, P8, P9} !== '0) begin
      errors++;
      $display("FAIL %s: got v=%0b e=%0b rdy=%0b w=%h expected v=0 e=0 rdy=1 w=0", name,
               win_valid, win_eof, in_ready, {P1, P2, P3, P4, P5, P6, P7, P8, P9});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  int base_w;
  int base_e;

  initial begin
    rst       = 1'b1;
    pix_in    = '0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    out_ready = 1'b0;
    or_mode   = 2;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset_state");
    @(posedge clk);
    #1;
    or_mode = 0;

    // Basic frame with a 5-cycle stall on the (3,4) window.
    base_w = win_cnt; base_e = eof_cnt;
    bp_arm = 1'b1;
    send_pixels(8'h00, 1'b1, 1'b0, H, 0);
    idle();
    drain();
    check_int("basic_windows", win_cnt - base_w, 24);
    check_int("basic_eof", eof_cnt - base_e, 1);
    check_int("backpressure_hit", int'(bp_hit), 1);

    // Random input bubbles and random output backpressure.
    or_mode = 1;
    base_w = win_cnt; base_e = eof_cnt;
    send_pixels(8'h00, 1'b1, 1'b1, H, 0);
    idle();
    drain();
    check_int("bubble_windows", win_cnt - base_w, 24);
    check_int("bubble_eof", eof_cnt - base_e, 1);
    or_mode = 0;

    // Two back-to-back frames, sof only on the first, distinct data in frame 2.
    base_w = win_cnt; base_e = eof_cnt;
    send_pixels(8'h00, 1'b1, 1'b0, H, 0);
    send_pixels(8'h80, 1'b0, 1'b0, H, 0);
    idle();
    drain();
    check_int("b2b_windows", win_cnt - base_w, 48);
    check_int("b2b_eof", eof_cnt - base_e, 2);

    // Mid-frame sof replacing pixel (3,5): 9 windows from the abandoned part, then 24.
    base_w = win_cnt; base_e = eof_cnt;
    send_pixels(8'h00, 1'b1, 1'b0, 3, 5);
    send_pixels(8'h40, 1'b1, 1'b0, H, 0);
    idle();
    drain();
    check_int("midsof_windows", win_cnt - base_w, 33);
    check_int("midsof_eof", eof_cnt - base_e, 1);

    // Reset in place of pixel (4,1), then a fresh frame with no sof.
    send_pixels(8'h00, 1'b1, 1'b0, 4, 1);
    idle();
    or_mode = 2;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("midframe_reset_state");
    @(posedge clk);
    #1;
    or_mode = 0;
    base_w = win_cnt; base_e = eof_cnt;
    send_pixels(8'h20, 1'b0, 1'b0, H, 0);
    idle();
    drain();
    check_int("post_reset_windows", win_cnt - base_w, 24);
    check_int("post_reset_eof", eof_cnt - base_e, 1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
